// File: rtl/mont_pkg.sv
// rtl/mont_pkg.sv - shared state encoding and phase constants for the Montgomery sequencer
package mont_pkg;

  localparam logic [3:0] PH_HOLD  = 4'h8;
  localparam logic [3:0] PH_FIRST = 4'd0;
  localparam logic [3:0] PH_LAST  = 4'd5;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    RESOLVE,
    SUB,
    DONE
  } state_e;

endpackage

// File: rtl/mont_phase_cnt.sv
// rtl/mont_phase_cnt.sv - adder slice phase counter 0..PH_LAST with clear/freeze and last-phase flag
module mont_phase_cnt
  import mont_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       freeze,
  input  logic       step,
  output logic [3:0] phase,
  output logic       last
);

  logic [3:0] phase_q, phase_d;

  assign phase = phase_q;
  assign last  = (phase_q == PH_LAST);

  always_comb begin
    phase_d = phase_q;
    if (freeze) begin
      phase_d = PH_HOLD;
    end else if (clear) begin
      phase_d = PH_FIRST;
    end else if (step && phase_q != PH_HOLD) begin
      // a bare step past the last phase wraps so the counter never leaves 0..5
      phase_d = last ? PH_FIRST : phase_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase_q <= PH_HOLD;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/mont_seq_ctrl.sv
// rtl/mont_seq_ctrl.sv - accumulate / resolve / conditional-subtract sequencer for the Montgomery adder
module mont_seq_ctrl
  import mont_pkg::*;
#(
  parameter int N_BITS  = 512,
  parameter int DIGIT_W = 2,
  parameter int N_ITER  = 257,
  parameter int MAX_SUB = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [N_BITS-1:0]  a_in,
  input  logic               sub_done,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [DIGIT_W-1:0] a_digit,
  output logic               acc_valid,
  output logic               c_doubleshift,
  output logic               subtract,
  output logic [3:0]         phase
);

  localparam int ITER_W = $clog2(N_ITER);
  localparam int PASS_W = $clog2(MAX_SUB);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(N_ITER - 1);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(MAX_SUB - 1);

  state_e              state_q, state_d;
  logic [N_BITS-1:0]   a_sr_q, a_sr_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                acc_valid_q, acc_valid_d;
  logic                cds_q, cds_d;
  logic                subtract_q, subtract_d;
  logic                ph_clear, ph_freeze, ph_step, ph_last;

  mont_phase_cnt u_phase_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clear  (ph_clear),
    .freeze (ph_freeze),
    .step   (ph_step),
    .phase  (phase),
    .last   (ph_last)
  );

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign a_digit       = a_sr_q[DIGIT_W-1:0];
  assign acc_valid     = acc_valid_q;
  assign c_doubleshift = cds_q;
  assign subtract      = subtract_q;

  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    iter_d      = iter_q;
    pass_d      = pass_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    acc_valid_d = acc_valid_q;
    cds_d       = cds_q;
    subtract_d  = subtract_q;
    ph_clear    = 1'b0;
    ph_freeze   = 1'b0;
    ph_step     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d      = a_in;
          iter_d      = '0;
          err_d       = 1'b0;
          busy_d      = 1'b1;
          acc_valid_d = 1'b1;
          cds_d       = 1'b1;
          state_d     = ACCUM;
        end
      end
      ACCUM: begin
        // exit is decided before incrementing, so iter never wraps and a_digit keeps its final value
        if (iter_q == ITER_LAST) begin
          acc_valid_d = 1'b0;
          cds_d       = 1'b0;
          ph_clear    = 1'b1;
          state_d     = RESOLVE;
        end else begin
          a_sr_d = a_sr_q >> DIGIT_W;
          iter_d = iter_q + 1'b1;
        end
      end
      RESOLVE: begin
        ph_step = 1'b1;
        if (ph_last) begin
          ph_clear   = 1'b1;
          pass_d     = '0;
          subtract_d = 1'b1;
          state_d    = SUB;
        end
      end
      SUB: begin
        ph_step = 1'b1;
        if (ph_last) begin
          if (sub_done || pass_q == PASS_LAST) begin
            err_d      = err_q | ~sub_done;
            done_d     = 1'b1;
            subtract_d = 1'b0;
            ph_freeze  = 1'b1;
            state_d    = DONE;
          end else begin
            pass_d   = pass_q + 1'b1;
            ph_clear = 1'b1;
          end
        end
      end
      DONE: begin
        busy_d    = 1'b0;
        ph_freeze = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        busy_d      = 1'b0;
        acc_valid_d = 1'b0;
        cds_d       = 1'b0;
        subtract_d  = 1'b0;
        ph_freeze   = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      a_sr_q      <= '0;
      iter_q      <= '0;
      pass_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      acc_valid_q <= 1'b0;
      cds_q       <= 1'b0;
      subtract_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      iter_q      <= iter_d;
      pass_q      <= pass_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      acc_valid_q <= acc_valid_d;
      cds_q       <= cds_d;
      subtract_q  <= subtract_d;
    end
  end

endmodule

// File: tb/tb_mont_seq_ctrl.sv
// tb/tb_mont_seq_ctrl.sv - self-checking bench for mont_seq_ctrl with a done/err scoreboard
module tb_mont_seq_ctrl;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [511:0] a_in;
  logic         sub_done;
  logic         busy, done, err, acc_valid, c_doubleshift, subtract;
  logic [1:0]   a_digit;
  logic [3:0]   phase;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int   cyc;
    logic err;
  } exp_t;
  exp_t sb[$];

  mont_seq_ctrl dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .a_in          (a_in),
    .sub_done      (sub_done),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .a_digit       (a_digit),
    .acc_valid     (acc_valid),
    .c_doubleshift (c_doubleshift),
    .subtract      (subtract),
    .phase         (phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand_a();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One full run. target = pass on which sub_done is raised (0 = never); always_done holds sub_done high.
  task automatic run(input int target, input bit always_done, input bit keep_start, input logic [511:0] a);
    int           passes, exp_cyc, cyc, p5, cds_n, ph_e;
    logic         sub_e, cds_e, err_e, got;
    logic [511:0] am;
    exp_t         e;
    passes  = always_done ? 1 : (target == 0 ? 4 : target);
    exp_cyc = 264 + 6 * passes;
    err_e   = (!always_done && target == 0);
    @(posedge clk);
    #1;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);
    sb.push_back('{exp_cyc, err_e});
    am       = a;
    a_in     = a;
    sub_done = always_done;
    start    = 1'b1;
    p5       = 0;
    cds_n    = 0;
    got      = 1'b0;
    @(posedge clk);
    cyc = 1;
    #1;
    if (!keep_start) start = 1'b0;
    while (!got && cyc <= exp_cyc + 8) begin
      if (cyc <= 257) begin
        ph_e = 8; sub_e = 1'b0; cds_e = 1'b1;
      end else if (cyc <= 263) begin
        ph_e = cyc - 258; sub_e = 1'b0; cds_e = 1'b0;
      end else if (cyc < exp_cyc) begin
        ph_e = (cyc - 264) % 6; sub_e = 1'b1; cds_e = 1'b0;
      end else begin
        ph_e = 8; sub_e = 1'b0; cds_e = 1'b0;
      end
      chk("phase", {28'd0, phase}, ph_e);
      chk("subtract", {31'd0, subtract}, {31'd0, sub_e});
      chk("c_doubleshift", {31'd0, c_doubleshift}, {31'd0, cds_e});
      chk("acc_valid", {31'd0, acc_valid}, {31'd0, cds_e});
      chk("a_digit", {30'd0, a_digit}, {30'd0, am[1:0]});
      chk("busy", {31'd0, busy}, 32'd1);
      chk("err_run", {31'd0, err}, {31'd0, (cyc >= exp_cyc) ? err_e : 1'b0});
      if (c_doubleshift === 1'b1) begin
        cds_n++;
        am = am >> 2;
      end
      if (done === 1'b1) begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("done_err", {31'd0, err}, {31'd0, e.err});
        chk("strobe_count", cds_n, 257);
        got = 1'b1;
      end else begin
        if (!always_done) begin
          sub_done = (subtract === 1'b1 && phase == 4'd5 && p5 == target - 1);
          if (subtract === 1'b1 && phase == 4'd5) p5++;
        end
        @(posedge clk);
        cyc++;
        #1;
      end
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
    sub_done = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    resetn   = 1'b0;
    start    = 1'b0;
    a_in     = '0;
    sub_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_a_digit", {30'd0, a_digit}, 32'd0);
    chk("rst_acc_valid", {31'd0, acc_valid}, 32'd0);
    chk("rst_cds", {31'd0, c_doubleshift}, 32'd0);
    chk("rst_subtract", {31'd0, subtract}, 32'd0);
    chk("rst_phase", {28'd0, phase}, 32'h8);
    @(negedge clk);
    resetn = 1'b1;

    // reset while accumulating at iter=100
    @(posedge clk);
    #1;
    a_in  = rand_a();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("mid_cds", {31'd0, c_doubleshift}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_phase", {28'd0, phase}, 32'h8);
    chk("mid_rst_cds", {31'd0, c_doubleshift}, 32'd0);
    chk("mid_rst_acc_valid", {31'd0, acc_valid}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_cds", {31'd0, c_doubleshift}, 32'd0);

    // digit sequence 01, 11, 0...; sub_done held high so it must be ignored until SUB phase 5
    run(1, 1'b1, 1'b0, 512'b1101);
    // sub_done on third pass
    run(3, 1'b0, 1'b0, rand_a());
    // sub_done never: error after MAX_SUB passes, sticky while idle
    run(0, 1'b0, 1'b0, rand_a());
    @(posedge clk);
    #1;
    chk("err_sticky", {31'd0, err}, 32'd1);
    chk("err_idle_busy", {31'd0, busy}, 32'd0);
    // start held high: back-to-back runs, first one also clears err
    run(1, 1'b0, 1'b1, rand_a());
    run(2, 1'b0, 1'b1, rand_a());
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("final_busy", {31'd0, busy}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
